// File: rtl/mem_access_unit.sv
// Memory-stage access controller: drives a stall-capable data memory via
// request/done handshake, stalls the pipeline, returns load data.
module mem_access_unit #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [DATA_W-1:0] addrIn,
    input  logic [DATA_W-1:0] wrtDataIn,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_busy,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              memStall,
    output logic [DATA_W-1:0] rdData,
    output logic              rdValid,
    output logic              errAlign,
    output logic              errTimeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              req;

    // Gated by rst so no input-driven pulse or stall leaks out during reset
    assign req = valid_in & (memRead | memWrite) & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        mem_en     = 1'b0;
        memStall   = 1'b0;
        rdValid    = 1'b0;
        errAlign   = 1'b0;
        errTimeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (addrIn[0]) begin
                        errAlign = 1'b1;
                    end else begin
                        memStall = 1'b1;
                        addr_d   = addrIn;
                        data_d   = wrtDataIn;
                        wr_d     = ~memRead;
                        state_d  = ACCESS;
                    end
                end
            end
            ACCESS: begin
                mem_en   = 1'b1;
                memStall = 1'b1;
                if (!mem_busy) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                memStall = 1'b1;
                // Completion takes priority over an expiring timeout
                if (mem_done) begin
                    if (!wr_q) rd_d = mem_rdata;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    errTimeout = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                rdValid = ~wr_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_wr    = mem_en & wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;
    assign rdData    = rd_q;

endmodule
